alu_gen: RTL

Parametrised next-generation ALU for the bus-based CPU datapath. It supports WIDTH-bit operands and 16 opcodes, including carry-chained arithmetic, logic ops, shifts and an iterative multi-cycle multiply. It uses a start/busy/done handshake, keeps a registered result (low and high halves) that drives the shared bus through tri-state, and holds a four-bit flag set (CF, ZF, NF, VF).

---
 rtl/alu_gen_pkg.sv | 24 ++
 rtl/alu_mul_iter.sv | 54 +++++
 rtl/alu_gen.sv | 124 ++++++++++++
 3 files changed

// File: rtl/alu_gen_pkg.sv
// Shared opcode encoding for the bus-attached ALU and its iterative multiplier.
package alu_gen_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD     = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB     = 4'd1;
    localparam logic [OP_W-1:0] OP_ADC     = 4'd2;
    localparam logic [OP_W-1:0] OP_SBB     = 4'd3;
    localparam logic [OP_W-1:0] OP_AND     = 4'd4;
    localparam logic [OP_W-1:0] OP_OR      = 4'd5;
    localparam logic [OP_W-1:0] OP_XOR     = 4'd6;
    localparam logic [OP_W-1:0] OP_NOT     = 4'd7;
    localparam logic [OP_W-1:0] OP_SHL     = 4'd8;
    localparam logic [OP_W-1:0] OP_SHR     = 4'd9;
    localparam logic [OP_W-1:0] OP_PASS    = 4'd10;
    localparam logic [OP_W-1:0] OP_MUL     = 4'd11;
    localparam logic [OP_W-1:0] OP_NOP_MIN = 4'd12;

    function automatic logic is_nop(input logic [OP_W-1:0] op);
        return op >= OP_NOP_MIN;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier: one partial-product step per clock, WIDTH steps.
module alu_mul_iter
    import alu_gen_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               finish
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;

    // product is the accumulator after this cycle's step; on the last step it is the full result
    assign addend  = lo_q[0] ? a_q : {WIDTH{1'b0}};
    assign sum     = {1'b0, hi_q} + {1'b0, addend};
    assign product = {sum, lo_q[WIDTH-1:1]};
    assign finish  = busy && (cnt_q == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
        end else if (start && !busy) begin
            a_q   <= a;
            hi_q  <= '0;
            lo_q  <= b;
            cnt_q <= CW'(WIDTH);
            busy  <= 1'b1;
        end else if (busy) begin
            {hi_q, lo_q} <= product;
            cnt_q        <= cnt_q - CW'(1);
            if (finish) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_gen.sv
// WIDTH-bit ALU with start/busy/done handshake, registered result halves on a tri-state bus and CF/ZF/NF/VF flags.
module alu_gen
    import alu_gen_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] reg_a,
    input  logic [WIDTH-1:0] reg_b,
    input  logic             enable_output,
    input  logic             enable_output_hi,
    output logic [WIDTH-1:0] bus,
    output logic             busy,
    output logic             done,
    output logic             CF,
    output logic             ZF,
    output logic             NF,
    output logic             VF
);

    logic [WIDTH-1:0]   result_lo;
    logic [WIDTH-1:0]   result_hi;
    logic               accept;
    logic               mul_start;
    logic               mul_finish;
    logic [2*WIDTH-1:0] mul_product;

    logic               is_sub;
    logic               cin;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     add_sum;
    logic               add_vf;
    logic [WIDTH-1:0]   alu_lo;
    logic               alu_cf;
    logic               alu_vf;

    assign accept    = start && !busy;
    assign mul_start = accept && (op == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (reg_a),
        .b       (reg_b),
        .product (mul_product),
        .busy    (busy),
        .finish  (mul_finish)
    );

    // One adder serves all four carry ops; ADC/SBB take the carry registered before this edge
    assign is_sub  = (op == OP_SUB) || (op == OP_SBB);
    assign b_eff   = is_sub ? ~reg_b : reg_b;
    assign cin     = (op == OP_SUB) ? 1'b1 : (op == OP_ADD) ? 1'b0 : CF;
    assign add_sum = {1'b0, reg_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    assign add_vf  = (reg_a[WIDTH-1] == b_eff[WIDTH-1]) && (add_sum[WIDTH-1] != reg_a[WIDTH-1]);

    always_comb begin
        alu_lo = '0;
        alu_cf = 1'b0;
        alu_vf = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBB: begin
                alu_lo = add_sum[WIDTH-1:0];
                alu_cf = add_sum[WIDTH];
                alu_vf = add_vf;
            end
            OP_AND:  alu_lo = reg_a & reg_b;
            OP_OR:   alu_lo = reg_a | reg_b;
            OP_XOR:  alu_lo = reg_a ^ reg_b;
            OP_NOT:  alu_lo = ~reg_a;
            OP_SHL: begin
                alu_lo = {reg_a[WIDTH-2:0], 1'b0};
                alu_cf = reg_a[WIDTH-1];
            end
            OP_SHR: begin
                alu_lo = {1'b0, reg_a[WIDTH-1:1]};
                alu_cf = reg_a[0];
            end
            OP_PASS: alu_lo = reg_b;
            default: alu_lo = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_lo <= '0;
            result_hi <= '0;
            CF        <= 1'b0;
            ZF        <= 1'b0;
            NF        <= 1'b0;
            VF        <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (mul_finish) begin
                result_lo <= mul_product[WIDTH-1:0];
                result_hi <= mul_product[2*WIDTH-1:WIDTH];
                ZF        <= (mul_product == '0);
                NF        <= mul_product[WIDTH-1];
                CF        <= |mul_product[2*WIDTH-1:WIDTH];
                VF        <= |mul_product[2*WIDTH-1:WIDTH];
                done      <= 1'b1;
            end else if (accept && (op != OP_MUL)) begin
                done <= 1'b1;
                if (!is_nop(op)) begin
                    result_lo <= alu_lo;
                    result_hi <= '0;
                    CF        <= alu_cf;
                    VF        <= alu_vf;
                    ZF        <= (alu_lo == '0);
                    NF        <= alu_lo[WIDTH-1];
                end
            end
        end
    end

    assign bus = enable_output    ? result_lo :
                 enable_output_hi ? result_hi : {WIDTH{1'bz}};

endmodule
